// File: rtl/crc32_frame_ctrl.sv
// crc32_frame_ctrl -- stream-side sequencer around a 32-bit combinational CRC.
//
// Generate mode (mode=0): forwards every word, accumulating the CRC, then
// appends the final CRC (crc_reg ^ CRC_XOROUT) as one extra trailing word.
// Check mode (mode=1): forwards every word; the last word of a frame is taken
// as the received CRC and compared against the accumulated value.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0=generate/append, 1=check (latched on first word)
//   s_valid/s_ready       input handshake, s_data[31:0], s_last
//   m_valid/m_ready       output handshake, m_data[31:0], m_last
//   crc_done, crc_err     1-cycle pulses at frame completion
//   crc_value[31:0]       final CRC of the last completed frame
//   stats_clr, frame_cnt[15:0], err_cnt[15:0]
//                         present only when CRC32_FRAME_STATS_EN is defined
//
// The CRC engine is the reflected CRC-32 (polynomial 0xEDB88320), consuming
// the 32 data bits LSB first.

module crc (
  input  logic [31:0] crcIn,
  input  logic [31:0] data,
  output logic [31:0] crcOut
);
  localparam logic [31:0] POLY = 32'hEDB8_8320;

  always_comb begin
    crcOut = crcIn;
    for (int unsigned i = 0; i < 32; i++) begin
      if (crcOut[0] ^ data[i]) crcOut = (crcOut >> 1) ^ POLY;
      else                     crcOut = crcOut >> 1;
    end
  end
endmodule

module crc32_frame_ctrl #(
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        crc_done,
  output logic        crc_err,
`ifdef CRC32_FRAME_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
`endif
  output logic [31:0] crc_value
);

  typedef enum logic {S_DATA, S_APPEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] value_q, value_d;
  logic        frame_mode_q, frame_mode_d;
  logic        in_frame_q, in_frame_d;

  logic [31:0] crc_out;
  logic        slot_free, accept, cur_mode;
  logic [31:0] final_crc;

  crc u_crc (
    .crcIn (crc_q),
    .data  (s_data),
    .crcOut(crc_out)
  );

  assign slot_free = !m_valid_q || m_ready;
  assign s_ready   = (state_q == S_DATA) && slot_free;
  assign accept    = s_valid && s_ready;
  // First word of a frame uses the live mode input; later words the latch.
  assign cur_mode  = in_frame_q ? frame_mode_q : mode;
  assign final_crc = crc_q ^ CRC_XOROUT;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    value_d      = value_q;
    frame_mode_d = frame_mode_q;
    in_frame_d   = in_frame_q;

    if (slot_free) m_valid_d = 1'b0;

    unique case (state_q)
      S_DATA: begin
        if (accept) begin
          m_valid_d  = 1'b1;
          m_data_d   = s_data;
          m_last_d   = 1'b0;
          in_frame_d = 1'b1;
          if (!in_frame_q) frame_mode_d = mode;
          if (!cur_mode) begin
            crc_d = crc_out;
            if (s_last) state_d = S_APPEND;
          end else if (!s_last) begin
            crc_d = crc_out;
          end else begin
            m_last_d   = 1'b1;
            value_d    = final_crc;
            done_d     = 1'b1;
            err_d      = (s_data != final_crc);
            crc_d      = CRC_INIT;
            in_frame_d = 1'b0;
          end
        end
      end
      S_APPEND: begin
        if (slot_free) begin
          m_valid_d  = 1'b1;
          m_data_d   = final_crc;
          m_last_d   = 1'b1;
          value_d    = final_crc;
          done_d     = 1'b1;
          crc_d      = CRC_INIT;
          in_frame_d = 1'b0;
          state_d    = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DATA;
      crc_q        <= CRC_INIT;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      value_q      <= '0;
      frame_mode_q <= 1'b0;
      in_frame_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      done_q       <= done_d;
      err_q        <= err_d;
      value_q      <= value_d;
      frame_mode_q <= frame_mode_d;
      in_frame_q   <= in_frame_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign crc_done  = done_q;
  assign crc_err   = err_q;
  assign crc_value = value_q;

`ifdef CRC32_FRAME_STATS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;

  // Counters follow the registered pulses; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (stats_clr) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (done_q && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (err_q && err_cnt_q != '1)    err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Self-checking bench for crc32_frame_ctrl: two instances (default seeds and
// all-zero seeds) share one stimulus stream; a scoreboard per instance holds
// the expected output words and completion events.
module tb_crc32_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, mode, s_valid, s_last, m_ready;
  logic [31:0] s_data;

  logic        s_ready0, m_valid0, m_last0, done0, err0;
  logic [31:0] m_data0, value0;
  logic        s_readyz, m_validz, m_lastz, donez, errz;
  logic [31:0] m_dataz, valuez;
`ifdef CRC32_FRAME_STATS_EN
  logic        stats_clr;
  logic [15:0] fc0, ec0, fcz, ecz;
`endif

  always #5 clk = ~clk;

  crc32_frame_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .m_last(m_last0),
    .crc_done(done0), .crc_err(err0),
`ifdef CRC32_FRAME_STATS_EN
    .stats_clr(stats_clr), .frame_cnt(fc0), .err_cnt(ec0),
`endif
    .crc_value(value0)
  );

  crc32_frame_ctrl #(.CRC_INIT(32'h0), .CRC_XOROUT(32'h0)) dutz (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_readyz), .s_data(s_data), .s_last(s_last),
    .m_valid(m_validz), .m_ready(m_ready), .m_data(m_dataz), .m_last(m_lastz),
    .crc_done(donez), .crc_err(errz),
`ifdef CRC32_FRAME_STATS_EN
    .stats_clr(stats_clr), .frame_cnt(fcz), .err_cnt(ecz),
`endif
    .crc_value(valuez)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed { logic [31:0] d; logic l; } word_t;
  typedef struct packed { logic e; logic [31:0] v; } done_t;
  word_t q0[$], qz[$];
  done_t d0[$], dz[$];
  word_t w0x, wzx;
  done_t e0x, ezx;
  int    errcnt0 = 0, errcntz = 0;

  // Reflected CRC-32, whole word folded in then shifted out.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c ^ d;
    for (int i = 0; i < 32; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] fw[8];
  int          fn;

  task automatic push_w(input bit z, input logic [31:0] d, input logic l);
    word_t w;
    w.d = d; w.l = l;
    if (z) qz.push_back(w); else q0.push_back(w);
  endtask

  task automatic push_d(input bit z, input logic e, input logic [31:0] v);
    done_t x;
    x.e = e; x.v = v;
    if (z) dz.push_back(x); else d0.push_back(x);
    if (e) begin
      if (z) errcntz++; else errcnt0++;
    end
  endtask

  task automatic model(input bit z, input bit chk_mode);
    logic [31:0] xo, c, ex;
    xo = z ? 32'h0 : 32'hFFFF_FFFF;
    c  = xo;   // seed and xorout coincide for both instances
    for (int i = 0; i < fn; i++) begin
      if (chk_mode && i == fn - 1) begin
        ex = c ^ xo;
        push_w(z, fw[i], 1'b1);
        push_d(z, fw[i] != ex, ex);
      end else begin
        push_w(z, fw[i], 1'b0);
        c = crc_step(c, fw[i]);
      end
    end
    if (!chk_mode) begin
      push_w(z, c ^ xo, 1'b1);
      push_d(z, 1'b0, c ^ xo);
    end
  endtask

  // Entered and left at posedge+2.
  task automatic drive_word(input logic [31:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk); acc = s_ready0;
      @(posedge clk); #2;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic do_stall(input logic [31:0] d, input logic l);
    logic [31:0] held;
    held = '0;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (j == 0) held = m_data0;
      check("stall_mvalid", m_valid0, 1);
      check("stall_mdata", m_data0, held);
      check("stall_sready", s_ready0, 0);
      @(posedge clk); #2;
    end
    m_ready = 1'b1;
  endtask

  task automatic send_frame(input bit chk_mode, input int stall_at);
    model(1'b0, chk_mode);
    model(1'b1, chk_mode);
    for (int i = 0; i < fn; i++) begin
      mode = (i == 0) ? chk_mode : ~chk_mode;  // mid-frame changes must be ignored
      if (i == stall_at) do_stall(fw[i], i == fn - 1);
      drive_word(fw[i], i == fn - 1);
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!chk_mode) begin
      @(negedge clk); check("append_sready_lo", s_ready0, 0);
      @(posedge clk); #2;
      @(negedge clk); check("append_sready_hi", s_ready0, 1);
      @(posedge clk); #2;
    end else begin
      @(negedge clk); check("b2b_sready", s_ready0, 1);
      @(posedge clk); #2;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid0 && m_ready) begin
        if (q0.size() == 0) check("w0_unexpected", 1, 0);
        else begin
          w0x = q0.pop_front();
          check("w0_data", m_data0, w0x.d);
          check("w0_last", m_last0, w0x.l);
        end
      end
      if (m_validz && m_ready) begin
        if (qz.size() == 0) check("wz_unexpected", 1, 0);
        else begin
          wzx = qz.pop_front();
          check("wz_data", m_dataz, wzx.d);
          check("wz_last", m_lastz, wzx.l);
        end
      end
      if (done0) begin
        if (d0.size() == 0) check("done0_unexpected", 1, 0);
        else begin
          e0x = d0.pop_front();
          check("err0", err0, e0x.e);
          check("value0", value0, e0x.v);
        end
      end else if (err0) check("err0_without_done", 1, 0);
      if (donez) begin
        if (dz.size() == 0) check("donez_unexpected", 1, 0);
        else begin
          ezx = dz.pop_front();
          check("errz", errz, ezx.e);
          check("valuez", valuez, ezx.v);
        end
      end else if (errz) check("errz_without_done", 1, 0);
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    m_ready = 1'b1;
`ifdef CRC32_FRAME_STATS_EN
    stats_clr = 1'b0;
`endif
    @(posedge clk); #2;
    check("rst_mvalid", m_valid0, 0);
    check("rst_mdata", m_data0, 0);
    check("rst_mlast", m_last0, 0);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_value", value0, 0);
    rst_n = 1'b1;
    @(negedge clk); check("post_rst_sready", s_ready0, 1);
    @(posedge clk); #2;

    fw[0] = 32'h0;          fw[1] = 32'h0;          fn = 2; send_frame(1'b0, -1);
    fw[0] = 32'h1234_5678;  fw[1] = 32'hDEAD_BEEF;  fn = 2; send_frame(1'b0, -1);
    fw[0] = 32'h0;          fw[1] = 32'h0;          fn = 2; send_frame(1'b1, -1);
    fw[0] = 32'h0;          fw[1] = 32'h1;          fn = 2; send_frame(1'b1, -1);
    fw[0] = 32'h7;                                  fn = 1; send_frame(1'b1, -1);
    fw[0] = 32'hCAFE_BABE;                          fn = 1; send_frame(1'b0, -1);
    fw[0] = 32'h11; fw[1] = 32'h22; fw[2] = 32'h33; fw[3] = 32'h44;
    fn = 4; send_frame(1'b0, 2);
    fw[0] = 32'h1; fw[1] = 32'h2; fw[2] = 32'h3;
    fw[3] = crc_step(crc_step(crc_step(32'hFFFF_FFFF, 32'h1), 32'h2), 32'h3) ^ 32'hFFFF_FFFF;
    fn = 4; send_frame(1'b1, 1);

    // Asynchronous reset while a generate frame is in flight.
    mode = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5_0F0F; s_last = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_mvalid0", m_valid0, 0);
    check("arst_mvalidz", m_validz, 0);
    check("arst_mdata", m_data0, 0);
    check("arst_done", done0, 0);
    check("arst_value", value0, 0);
    s_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    fw[0] = 32'h1234_5678;  fw[1] = 32'hDEAD_BEEF;  fn = 2; send_frame(1'b0, -1);

`ifdef CRC32_FRAME_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk); #2;
    stats_clr = 1'b0;
    errcnt0 = 0; errcntz = 0;
    fw[0] = 32'h0; fw[1] = 32'h0;                fn = 2; send_frame(1'b1, -1);
    fw[0] = 32'h5; fw[1] = crc_step(32'h0, 32'h5); fn = 2; send_frame(1'b1, -1);
    fw[0] = 32'h0; fw[1] = 32'h1;                fn = 2; send_frame(1'b1, -1);
    repeat (2) @(posedge clk); #2;
    check("frame_cnt0", fc0, 3);
    check("frame_cntz", fcz, 3);
    check("err_cnt0", ec0, errcnt0);
    check("err_cntz", ecz, errcntz);
    stats_clr = 1'b1;
    fw[0] = 32'h0; fn = 1; send_frame(1'b1, -1);
    @(posedge clk); #2;
    stats_clr = 1'b0;
    repeat (2) @(posedge clk); #2;
    check("clr_frame_cnt", fcz, 0);
    check("clr_err_cnt", ecz, 0);
`endif

    for (int k = 0; k < 20; k++) begin
      if (q0.size() == 0 && qz.size() == 0 && d0.size() == 0 && dz.size() == 0) break;
      @(negedge clk);
    end
    check("drain_q0", q0.size(), 0);
    check("drain_qz", qz.size(), 0);
    check("drain_d0", d0.size(), 0);
    check("drain_dz", dz.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
